// File: rtl/multi_dma_w_pkg.sv
// multi_dma_w_pkg: shared constants, arbiter states, channel record and eligibility helper
package multi_dma_w_pkg;
   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int BS   = DW / 8;
   localparam int AL   = $clog2(BS);
   localparam int BL   = 3;
   localparam int MAXB = 2 ** BL;
   localparam int LW   = 24;
   localparam int CH   = 3;
   localparam int CW   = $clog2(CH + 1);
   typedef enum logic [1:0] {IDLE, BURST, UPD} arb_state_t;
   typedef struct packed {
      logic [AW-1:0] adr;
      logic [LW-1:0] rem;
      logic          busy;
      logic          closed;
      logic          is_short;
   } chan_t;
   function automatic logic eligible(input chan_t c, input logic [BL:0] cnt);
      logic [LW-1:0] need;
      need = (c.rem < LW'(MAXB)) ? c.rem : LW'(MAXB);
      return c.busy && ((c.closed && cnt != '0) || (LW'(cnt) >= need));
   endfunction
endpackage

// File: rtl/multi_dma_w_if.sv
// multi_dma_w_if: PIO, pixel stream, status and Avalon burst-write signals
interface multi_dma_w_if;
   import multi_dma_w_pkg::*;
   logic [CH-1:0]         pio_adr_we;
   logic [CH-1:0]         pio_len_we;
   logic [31:0]           pio_d;
   logic [CH-1:0]         s_val;
   logic [CH-1:0]         s_rdy;
   logic [CH-1:0]         s_eof;
   logic [CH-1:0][DW-1:0] s_dat;
   logic [CH-1:0]         dma_done;
   logic [CH-1:0]         dma_err;
   logic                  bus_wrdy;
   logic                  bus_wval;
   logic [BL:0]           bus_wlen;
   logic [AW-1:0]         bus_waddr;
   logic [DW-1:0]         bus_wdata;
   modport slave (
      input  pio_adr_we, pio_len_we, pio_d, s_val, s_eof, s_dat, bus_wrdy,
      output s_rdy, dma_done, dma_err, bus_wval, bus_wlen, bus_waddr, bus_wdata
   );
   modport master (
      output pio_adr_we, pio_len_we, pio_d, s_val, s_eof, s_dat, bus_wrdy,
      input  s_rdy, dma_done, dma_err, bus_wval, bus_wlen, bus_waddr, bus_wdata
   );
endinterface

// File: rtl/multi_dma_w_fifo.sv
// multi_dma_w_fifo: synchronous W x 2**L FIFO with occupancy count
module multi_dma_w_fifo #(
   parameter int W = 64,
   parameter int L = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic [L:0]   o_cnt
);
   logic [W-1:0] r_mem [2**L];
   logic [L-1:0] r_wp, r_rp;
   logic [L:0]   r_cnt;
   logic         w_push, w_pop;
   assign w_pop  = i_pop && r_cnt != '0;
   assign w_push = i_push && (!o_full || w_pop);
   assign o_full = r_cnt[L];
   assign o_cnt  = r_cnt;
   assign o_dout = r_mem[r_rp];
   // storage write, no reset needed on the data array
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_din;
   // pointers and count; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk)
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + L'(w_push);
         r_rp  <= r_rp + L'(w_pop);
         r_cnt <= r_cnt + (L+1)'(w_push) - (L+1)'(w_pop);
      end
endmodule

// File: rtl/multi_dma_w.sv
// multi_dma_w: multi-channel stream-to-memory write DMA with round-robin burst arbiter
module multi_dma_w
   import multi_dma_w_pkg::*;
(
   input logic          clk,
   input logic          rst,
   multi_dma_w_if.slave bus_if
);
   arb_state_t    r_state, w_state_nxt;
   chan_t         r_ch  [CH];
   logic [LW-1:0] r_acc [CH];
   logic [BL:0]   w_cnt [CH];
   logic [DW-1:0] w_head[CH];
   logic [CH-1:0] w_full, w_push, w_pop, w_elig, w_rdy, w_cfg_ok, r_done, r_err;
   logic [CW-1:0] r_gnt, r_ptr, w_pick;
   logic          w_any;
   logic [BL:0]   r_beat, r_wlen;
   logic [AW-1:0] r_waddr;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      assign w_rdy[i]    = r_ch[i].busy && !r_ch[i].closed && !w_full[i] && r_acc[i] != '0;
      assign w_push[i]   = bus_if.s_val[i] && w_rdy[i];
      assign w_pop[i]    = r_state == BURST && r_gnt == CW'(i) && bus_if.bus_wrdy;
      assign w_elig[i]   = eligible(r_ch[i], w_cnt[i]);
      assign w_cfg_ok[i] = bus_if.pio_d[LW-1:0] != '0 && bus_if.pio_d[AL-1:0] == '0 &&
                           (bus_if.pio_adr_we[i] ? bus_if.pio_d[AL-1:0] : r_ch[i].adr[AL-1:0]) == '0;
      multi_dma_w_fifo #(.W(DW), .L(BL)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .i_push(w_push[i]),
         .i_din (bus_if.s_dat[i]),
         .i_pop (w_pop[i]),
         .o_dout(w_head[i]),
         .o_full(w_full[i]),
         .o_cnt (w_cnt[i])
      );
   end

   assign bus_if.s_rdy     = w_rdy;
   assign bus_if.dma_done  = r_done;
   assign bus_if.dma_err   = r_err;
   assign bus_if.bus_wval  = r_state == BURST;
   assign bus_if.bus_wlen  = r_wlen;
   assign bus_if.bus_waddr = r_waddr;
   assign bus_if.bus_wdata = r_state == BURST ? w_head[r_gnt] : '0;

   // round-robin search starting at r_ptr; lowest offset wins
   always_comb begin
      w_pick = '0;
      w_any  = 1'b0;
      for (int k = CH - 1; k >= 0; k--)
         if (w_elig[(int'(r_ptr) + k) % CH]) begin
            w_any  = 1'b1;
            w_pick = CW'((int'(r_ptr) + k) % CH);
         end
   end

   // arbiter next state: grant, stream n beats, then one update cycle
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = r_state == IDLE  ? (w_any ? BURST : IDLE) :
                    r_state == BURST ? ((bus_if.bus_wrdy && r_beat == (BL+1)'(1)) ? UPD : BURST) :
                                       IDLE;
   end

   // arbiter state register
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;

   // grant latch: burst address and length are frozen for the whole burst
   always_ff @(posedge clk)
      if (rst) begin
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_waddr <= '0;
         r_wlen  <= '0;
         r_beat  <= '0;
      end else if (r_state == IDLE && w_any) begin
         r_gnt   <= w_pick;
         r_ptr   <= w_pick == CW'(CH - 1) ? '0 : w_pick + 1'b1;
         r_waddr <= r_ch[w_pick].adr;
         r_wlen  <= w_cnt[w_pick];
         r_beat  <= w_cnt[w_pick];
      end else if (r_state == BURST && bus_if.bus_wrdy) begin
         r_beat  <= r_beat - 1'b1;
      end

   // per-channel programming, input accounting, completion and error pulses
   always_ff @(posedge clk) begin
      r_done <= '0;
      r_err  <= '0;
      if (rst) begin
         for (int k = 0; k < CH; k++) begin
            r_ch[k]  <= '0;
            r_acc[k] <= '0;
         end
      end else begin
         for (int k = 0; k < CH; k++) begin
            if (bus_if.pio_adr_we[k] || bus_if.pio_len_we[k]) begin
               if (r_ch[k].busy) r_err[k] <= 1'b1;
               else begin
                  if (bus_if.pio_adr_we[k]) r_ch[k].adr <= bus_if.pio_d;
                  if (bus_if.pio_len_we[k] && w_cfg_ok[k]) begin
                     r_ch[k].rem      <= bus_if.pio_d[LW-1:0] >> AL;
                     r_acc[k]         <= bus_if.pio_d[LW-1:0] >> AL;
                     r_ch[k].busy     <= 1'b1;
                     r_ch[k].closed   <= 1'b0;
                     r_ch[k].is_short <= 1'b0;
                  end else if (bus_if.pio_len_we[k]) r_err[k] <= 1'b1;
               end
            end
            if (w_push[k]) begin
               r_acc[k] <= r_acc[k] - 1'b1;
               if (bus_if.s_eof[k] || r_acc[k] == LW'(1)) r_ch[k].closed <= 1'b1;
               if (bus_if.s_eof[k] && r_acc[k] != LW'(1)) r_ch[k].is_short <= 1'b1;
            end
            if (r_state == UPD && r_gnt == CW'(k)) begin
               r_ch[k].adr <= r_ch[k].adr + (AW'(r_wlen) << AL);
               r_ch[k].rem <= r_ch[k].rem - LW'(r_wlen);
               if (r_ch[k].rem == LW'(r_wlen) || (r_ch[k].closed && w_cnt[k] == '0)) begin
                  r_ch[k].busy <= 1'b0;
                  r_done[k]    <= 1'b1;
                  if (r_ch[k].is_short) r_err[k] <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: doc/multi_dma_w.md
# multi_dma_w

Multi-channel streaming write DMA: accepts up to CH independent DW-bit valid/ready pixel streams and writes each into its own linear buffer in SDRAM through a single Avalon-MM burst-write master. Channels are programmed over the PIO register strobes and arbitrated round-robin per burst. It is the write-side companion of `multi_xyz_dma_r` and drives the write port of the shared `xlib_avalon_ram`/SDRAM controller.

## Interface
- `AW`, 32: bus byte-address width.
- `DW`, 64: data width; `BS = DW/8` bytes per word.
- `AL`, `$clog2(BS)`: address alignment bits.
- `BL`, 3: burst-size exponent; `MAXB = 2**BL` words per burst, also the per-channel FIFO depth.
- `LW`, 24: byte-length register width.
- `CH`, 3: channel count.
- `CW`, `$clog2(CH+1)`: channel index width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  **synchronous, active-high** reset.
- `pio_adr_we`  in  CH  per-channel start-address write strobe.
- `pio_len_we`  in  CH  per-channel length write strobe; arms the channel.
- `pio_d`  in  32  PIO write data.
- `s_val`  in  CH  stream valid.
- `s_rdy`  out  CH  stream ready.
- `s_eof`  in  CH  marks the last word of a frame.
- `s_dat`  in  CH×DW  stream data.
- `dma_done`  out  CH  one-cycle completion pulse.
- `dma_err`  out  CH  one-cycle error pulse.
- `bus_wrdy`  in  1  Avalon waitrequest_n.
- `bus_wval`  out  1  write valid.
- `bus_wlen`  out  BL+1  burst count in words, 1..MAXB.
- `bus_waddr`  out  AW  burst start byte address.
- `bus_wdata`  out  DW  write data.

## Operation
- **Per-channel registers:** `adr`, `len`, `rem` (remaining words), `busy`.
- **Address write** (`pio_adr_we[i]`, `busy=0`): latch `adr = pio_d`.
- **Length write** (`pio_len_we[i]`, `busy=0`):
  - If `pio_d[LW-1:0]` is nonzero, a multiple of BS, and `adr[AL-1:0]==0`: `rem = len>>AL`, `busy=1`.
  - Otherwise pulse `dma_err[i]` and do not arm.
- **PIO write while `busy=1`:** ignored, and `dma_err[i]` pulses.
- **Stream acceptance:** `s_rdy[i] = busy & ~fifo_full & (accepted < rem_total)`. A word is accepted on `s_val & s_rdy`.
- **Early eof:** `s_eof` on a word before the length is reached closes input and records `short=1`.
- **Missing eof:** if the last word arrives without eof, the transfer still completes with no error.
- **Burst eligibility:** a channel is eligible when it is busy and
  - its FIFO count ≥ min(MAXB, `rem`), or
  - input is closed and the FIFO count is > 0.
- **Arbiter FSM:**
  - `IDLE`: round-robin pick of an eligible channel, starting after the last granted index. Latch `bus_waddr = adr`, `bus_wlen = n`, where n = min(MAXB, FIFO count). Go to `BURST`.
  - `BURST`: `bus_wval=1`, `bus_wdata` = FIFO head. Each `bus_wval & bus_wrdy` pops one word. After the n-th beat go to `UPD`.
  - `UPD`: `adr += n*BS`, `rem -= n`. If `rem==0` or (closed and FIFO empty): clear `busy`, pulse `dma_done[i]`, and pulse `dma_err[i]` too if `short`. Then go to `IDLE`.
- `bus_waddr` and `bus_wlen` stay constant for the whole burst.
- Arithmetic: `adr` is modulo 2^AW with wrap and no error; `rem` never underflows, because n ≤ `rem`.

## Timing
- **Reset values:** all outputs 0; FIFOs empty; all channels idle; round-robin pointer = channel 0.
- **`IDLE`→`BURST`:** 1 cycle after eligibility. `bus_wval` rises on the cycle after the grant.
- **Burst throughput:** one beat per cycle while `bus_wrdy=1`. Stalls are unbounded; `bus_wval` never drops mid-burst.
- **`dma_done`:** asserts exactly 2 cycles after the final accepted beat (`UPD`, then the registered pulse).
- **`dma_err` for config errors:** asserts 1 cycle after the offending strobe.
- **Simultaneous events:**
  - `pio_adr_we` and `pio_len_we` in the same cycle: the length check uses the *new* address.
  - A push and pop on the same FIFO in one cycle are both honoured; the count is unchanged.
- **Reset mid-burst:** `bus_wval` drops on the next edge, and the partial burst is abandoned. The SDRAM model tolerates this only under reset.

## Structure
- Shared package `multi_dma_w_pkg`:
  - `arb_state_t` enum {IDLE, BURST, UPD}.
  - `MAXB` constant.
  - `chan_t` struct {adr, rem, busy, closed, short}.
- Sub-module `multi_dma_w_fifo`: synchronous DW×MAXB FIFO with count output, instantiated CH times via a generate loop.

## Test plan
- **Single channel, aligned:** ch0 adr=0x0, len=0x40 (8 words), continuous stream → one burst with waddr=0x0, wlen=8; memory matches; `dma_done[0]` pulses once; no err.
- **Three channels concurrent:** lengths 0x12c00 each, bases 0/0x12c00/0x25800, random `s_val` at 20% and `bus_wrdy` at 80% → bursts interleave round-robin; all three buffers match byte-for-byte; three done pulses.
- **Tail burst:** len=0x58 (11 words) → bursts of 8 then 3 words at 0x0 and 0x40; done after the second.
- **Early eof:** len=0x80, eof on word 5 → a 5-word burst is written, then `dma_done` and `dma_err` pulse together; `s_rdy` is low after word 5.
- **Bad config:** adr=0x4 then len=0x40, or len=0x44 → `dma_err` pulses 1 cycle after `pio_len_we`; channel stays idle; `s_rdy` stays 0.
- **Reset mid-burst:** assert `rst` during beat 3 → the next cycle has `bus_wval=0` and `s_rdy=0`; re-arming after reset completes normally.
